stage_mem: RTL and testbench

//  Memory-access stage between EX and WB. Performs loads and stores on a Wishbone-classic data bus.

---
 rtl/stage_mem_pkg.sv | 64 ++++++
 rtl/stage_mem_load_align.sv | 37 +++
 rtl/stage_mem.sv | 197 +++++++++++++++++++
 tb/tb_stage_mem.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// ---------------------------------------------------------------------------
// stage_mem_pkg
// Shared definitions for the memory-access pipeline stage:
//   - funct3 load/store size codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - bus FSM state encoding (S_IDLE, S_BUS)
//   - helpers for legality, misalignment, byte lanes and store replication
// ---------------------------------------------------------------------------
package stage_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    // Loads accept all five size codes
    function automatic logic isLdF3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Stores have no unsigned variants
    function automatic logic isStF3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic misAligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return (a != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Loads use the same lanes as the equivalent store
    function automatic logic [3:0] laneSel(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << a;
            F3_H, F3_HU: return 4'b0011 << {a[1], 1'b0};
            default:     return 4'hF;
        endcase
    endfunction

    // Replicate the store operand across every lane so the slave can pick
    // its bytes using wbm_sel_o alone
    function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_load_align.sv
// ---------------------------------------------------------------------------
// stage_mem_load_align
// Combinational load-data aligner: selects the addressed byte/half/word of a
// raw bus word and sign- or zero-extends it to 32 bits. Kept free of any
// state so an instruction-side fetch unit can reuse it.
// Ports:
//   funct3_i  access size/sign code
//   addr_i    low two address bits of the access
//   data_i    raw 32-bit bus word
//   data_o    aligned and extended result
// ---------------------------------------------------------------------------
module stage_mem_load_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Pick the addressed lane, then extend according to the size code
    always_comb begin
        byteVal = data_i[{addr_i, 3'b000} +: 8];
        halfVal = data_i[{addr_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{24{byteVal[7]}}, byteVal};
            F3_H:    data_o = {{16{halfVal[15]}}, halfVal};
            F3_BU:   data_o = {24'h000000, byteVal};
            F3_HU:   data_o = {16'h0000, halfVal};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// ---------------------------------------------------------------------------
// stage_mem
// Memory-access stage between EX and WB. Runs loads and stores as
// Wishbone-classic cycles, stalls the pipeline while a cycle is outstanding,
// aligns/extends load data and flags misalignment and bus errors.
// Parameters:
//   BUS_TIMEOUT  cycles allowed for ack/err before a forced bus error (0 = off)
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   valid_i, kill_i            instruction present / flush from WB
//   is_ld_mem_i, is_st_mem_i   load / store qualifiers
//   funct3_i, addr_i, st_data_i access size, effective address, store operand
//   ld_data_o                  aligned load data for WB
//   mem_addr_o                 address of current/last access
//   e_ld_addr_mis_o, e_st_addr_mis_o, e_bus_err_o  exception flags
//   stall_o                    hold IF..MEM pipeline registers
//   wbm_*                      Wishbone-classic master interface
// ---------------------------------------------------------------------------
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        kill_i,
    input  logic        is_ld_mem_i,
    input  logic        is_st_mem_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] mem_addr_o,
    output logic        e_ld_addr_mis_o,
    output logic        e_st_addr_mis_o,
    output logic        e_bus_err_o,
    output logic        stall_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int CNT_W_RAW = $clog2(BUS_TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int TO_LAST_I = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic TO_EN = (BUS_TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       memAddr_q, memAddr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       ldHold_q, ldHold_d;
    logic              busErr_q, busErr_d;
    logic              killed_q, killed_d;

    logic              ldOk, stOk, misAlign, start, timeout, killNow, stall;
    logic [31:0]       alignedData, ldData;

    // Unsupported size codes are neither legal nor misaligned, so they
    // silently never start an access
    assign ldOk     = is_ld_mem_i & isLdF3(funct3_i);
    assign stOk     = is_st_mem_i & isStF3(funct3_i);
    assign misAlign = misAligned(funct3_i, addr_i[1:0]);
    assign start    = (state_q == S_IDLE) & valid_i & (ldOk | stOk) & ~misAlign & ~kill_i;
    assign timeout  = TO_EN & (cnt_q == TO_LAST);

    assign e_ld_addr_mis_o = valid_i & ldOk & misAlign;
    assign e_st_addr_mis_o = valid_i & stOk & misAlign;

    stage_mem_load_align uAlign (
        .funct3_i (funct3_q),
        .addr_i   (memAddr_q[1:0]),
        .data_i   (wbm_dat_i),
        .data_o   (alignedData)
    );

    // Next-state logic. Error beats ack, ack beats the watchdog. A kill seen
    // at any point of the bus cycle is remembered so the completion can drop
    // load data and error reporting even if kill_i was only a pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        memAddr_d = memAddr_q;
        funct3_d  = funct3_q;
        ldHold_d  = ldHold_q;
        busErr_d  = 1'b0;
        killed_d  = killed_q;
        killNow   = killed_q | kill_i;
        ldData    = ldHold_q;
        stall     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_BUS;
                    cnt_d     = '0;
                    cyc_d     = 1'b1;
                    we_d      = is_st_mem_i;
                    adr_d     = {addr_i[31:2], 2'b00};
                    sel_d     = laneSel(funct3_i, addr_i[1:0]);
                    dat_d     = storeData(funct3_i, st_data_i);
                    memAddr_d = addr_i;
                    funct3_d  = funct3_i;
                    killed_d  = 1'b0;
                    stall     = 1'b1;
                end
            end
            S_BUS: begin
                if (wbm_err_i) begin
                    state_d  = S_IDLE;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    busErr_d = ~killNow;
                end else if (wbm_ack_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q && !killNow) begin
                        ldData   = alignedData;
                        ldHold_d = alignedData;
                    end
                end else if (timeout) begin
                    state_d  = S_IDLE;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    busErr_d = ~killNow;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    killed_d = killNow;
                    stall    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops cyc/stb immediately
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            memAddr_q <= '0;
            funct3_q  <= '0;
            ldHold_q  <= '0;
            busErr_q  <= 1'b0;
            killed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            memAddr_q <= memAddr_d;
            funct3_q  <= funct3_d;
            ldHold_q  <= ldHold_d;
            busErr_q  <= busErr_d;
            killed_q  <= killed_d;
        end
    end

    assign ld_data_o   = ldData;
    assign mem_addr_o  = memAddr_q;
    assign e_bus_err_o = busErr_q;
    assign stall_o     = stall;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;

endmodule

// File: tb/tb_stage_mem.sv
// ---------------------------------------------------------------------------
// tb_stage_mem
// Directed bench for stage_mem. The stimulus process pushes the expected bus
// request and completion result into queues; a monitor pops them when the
// DUT raises or drops wbm_cyc_o. A second instance with a short watchdog
// covers the timeout path.
// ---------------------------------------------------------------------------
module tb_stage_mem;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
        logic [31:0] memAddr;
    } reqT;

    typedef struct {
        logic [31:0] ld;
        logic        err;
        logic [31:0] memAddr;
    } respT;

    reqT  reqQ[$];
    respT respQ[$];

    int compared   = 0;
    int mismatched = 0;

    logic        clk = 1'b0;
    logic        rstN, valid, validTo, kill, isLd, isSt, ack, err;
    logic [2:0]  funct3;
    logic [31:0] addrIn, stData, rdata;

    logic [31:0] ldData, memAddr, adr, datO;
    logic        misLd, misSt, busErr, stall, we, cyc, stb;
    logic [3:0]  sel;

    logic [31:0] ldDataTo, memAddrTo, adrTo, datOTo;
    logic        misLdTo, misStTo, busErrTo, stallTo, weTo, cycTo, stbTo;
    logic [3:0]  selTo;

    always #5 clk = ~clk;

    stage_mem dut (
        .clk_i(clk), .rst_i(rstN), .valid_i(valid), .kill_i(kill),
        .is_ld_mem_i(isLd), .is_st_mem_i(isSt), .funct3_i(funct3),
        .addr_i(addrIn), .st_data_i(stData),
        .ld_data_o(ldData), .mem_addr_o(memAddr),
        .e_ld_addr_mis_o(misLd), .e_st_addr_mis_o(misSt), .e_bus_err_o(busErr),
        .stall_o(stall), .wbm_adr_o(adr), .wbm_dat_o(datO), .wbm_sel_o(sel),
        .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
        .wbm_dat_i(rdata), .wbm_ack_i(ack), .wbm_err_i(err)
    );

    stage_mem #(.BUS_TIMEOUT(4)) dutTo (
        .clk_i(clk), .rst_i(rstN), .valid_i(validTo), .kill_i(kill),
        .is_ld_mem_i(isLd), .is_st_mem_i(isSt), .funct3_i(funct3),
        .addr_i(addrIn), .st_data_i(stData),
        .ld_data_o(ldDataTo), .mem_addr_o(memAddrTo),
        .e_ld_addr_mis_o(misLdTo), .e_st_addr_mis_o(misStTo), .e_bus_err_o(busErrTo),
        .stall_o(stallTo), .wbm_adr_o(adrTo), .wbm_dat_o(datOTo), .wbm_sel_o(selTo),
        .wbm_we_o(weTo), .wbm_cyc_o(cycTo), .wbm_stb_o(stbTo),
        .wbm_dat_i(rdata), .wbm_ack_i(ack), .wbm_err_i(err)
    );

    // Shared comparison: bumps the counters and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One instruction through MEM, acting as pipeline and bus slave.
    // resp: 0 = ack, 1 = err, 2 = silent. killAt = cycle index of a kill pulse.
    task automatic applyStimulus(
        input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] sd,
        input int waits, input int resp, input int killAt, input logic [31:0] rdat,
        input logic expMisLd, input logic expMisSt, input int expStall,
        input logic [31:0] expLd, input logic expErr,
        input logic startsBus, input logic [3:0] expSel, input logic [31:0] expDat);
        int  stallCnt;
        int  busCyc;
        bit  done;
        if (startsBus) begin
            reqQ.push_back('{adr: {a[31:2], 2'b00}, sel: expSel, dat: expDat, we: st, memAddr: a});
            respQ.push_back('{ld: expLd, err: expErr, memAddr: a});
        end
        valid = 1'b1; isLd = ld; isSt = st; funct3 = f3; addrIn = a; stData = sd;
        stallCnt = 0; busCyc = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            kill = (c == killAt);
            ack = 1'b0; err = 1'b0; rdata = 32'h0;
            if (cyc) begin
                busCyc++;
                if (busCyc == waits + 1) begin
                    if (resp == 0) begin ack = 1'b1; rdata = rdat; end
                    else if (resp == 1) err = 1'b1;
                end
            end
            @(negedge clk);
            if (c == 0) begin
                checkOutput("e_ld_addr_mis", {31'b0, misLd}, {31'b0, expMisLd});
                checkOutput("e_st_addr_mis", {31'b0, misSt}, {31'b0, expMisSt});
            end
            if (stall) stallCnt++;
            else begin
                done = 1'b1;
                checkOutput("ldDataAtDone", ldData, expLd);
            end
            @(posedge clk); #1;
        end
        if (!done) checkOutput("accessBudget", 32'd0, 32'd1);
        valid = 1'b0; isLd = 1'b0; isSt = 1'b0; kill = 1'b0; ack = 1'b0; err = 1'b0;
        checkOutput("stallCycles", stallCnt, expStall);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("errPulseEnd", {31'b0, busErr}, 32'd0);
        checkOutput("cycIdle", {31'b0, cyc}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compares the bus request when cyc rises and the completion
    // result when cyc falls
    initial begin : monitor
        logic prevCyc;
        reqT  r;
        respT p;
        prevCyc = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc && !prevCyc) begin
                if (reqQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL busStart: unexpected cycle at adr 0x%08h, expected none", adr);
                end else begin
                    r = reqQ.pop_front();
                    checkOutput("wbm_adr", adr, r.adr);
                    checkOutput("wbm_sel", {28'b0, sel}, {28'b0, r.sel});
                    checkOutput("wbm_we", {31'b0, we}, {31'b0, r.we});
                    checkOutput("wbm_stb", {31'b0, stb}, 32'd1);
                    checkOutput("mem_addr", memAddr, r.memAddr);
                    if (r.we) checkOutput("wbm_dat", datO, r.dat);
                end
            end
            if (!cyc && prevCyc) begin
                if (respQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL busEnd: unexpected completion, expected none");
                end else begin
                    p = respQ.pop_front();
                    checkOutput("ldDataHeld", ldData, p.ld);
                    checkOutput("e_bus_err", {31'b0, busErr}, {31'b0, p.err});
                    checkOutput("memAddrHeld", memAddr, p.memAddr);
                end
            end
            prevCyc = cyc;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL simTimeout: simulation still running, expected finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin : stimulus
        int cycCnt;
        int stallCnt;
        bit done;
        rstN = 1'b0; valid = 1'b0; validTo = 1'b0; kill = 1'b0; isLd = 1'b0; isSt = 1'b0;
        funct3 = 3'b0; addrIn = 32'h0; stData = 32'h0; rdata = 32'h0; ack = 1'b0; err = 1'b0;

        $display("[TB] reset state");
        @(posedge clk); @(negedge clk);
        checkOutput("rst_cyc", {31'b0, cyc}, 32'd0);
        checkOutput("rst_stb", {31'b0, stb}, 32'd0);
        checkOutput("rst_we", {31'b0, we}, 32'd0);
        checkOutput("rst_adr", adr, 32'd0);
        checkOutput("rst_sel", {28'b0, sel}, 32'd0);
        checkOutput("rst_dat", datO, 32'd0);
        checkOutput("rst_ld_data", ldData, 32'd0);
        checkOutput("rst_mem_addr", memAddr, 32'd0);
        checkOutput("rst_bus_err", {31'b0, busErr}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] loads and stores");
        //            ld    st    f3      addr          st_data       w  r  k   rdata         mL    mS    stl ld_exp        err   bus   sel    dat
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,        3, 0, -1, 32'hDEADBEEF, 1'b0, 1'b0, 4, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h00000203, 32'h0,        0, 0, -1, 32'h80112233, 1'b0, 1'b0, 1, 32'hFFFFFF80, 1'b0, 1'b1, 4'h8, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h00000203, 32'h0,        0, 0, -1, 32'h80112233, 1'b0, 1'b0, 1, 32'h00000080, 1'b0, 1'b1, 4'h8, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h00000006, 32'h1234ABCD, 1, 0, -1, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 32'h00000080, 1'b0, 1'b1, 4'hC, 32'hABCDABCD);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,        0, 0, -1, 32'h0,        1'b1, 1'b0, 0, 32'h00000080, 1'b0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h00000001, 32'h0,        0, 0, -1, 32'h0,        1'b0, 1'b1, 0, 32'h00000080, 1'b0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h00000002, 32'h0,        0, 0, -1, 32'h80017FFF, 1'b0, 1'b0, 1, 32'hFFFF8001, 1'b0, 1'b1, 4'hC, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h00000000, 32'h0,        0, 0, -1, 32'h80017FFF, 1'b0, 1'b0, 1, 32'h00007FFF, 1'b0, 1'b1, 4'h3, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h00000001, 32'h000000A5, 0, 0, -1, 32'h0,        1'b0, 1'b0, 1, 32'h00007FFF, 1'b0, 1'b1, 4'h2, 32'hA5A5A5A5);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h00000008, 32'hCAFEF00D, 0, 0, -1, 32'h0,        1'b0, 1'b0, 1, 32'h00007FFF, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0,        0, 0, -1, 32'h0,        1'b0, 1'b0, 0, 32'h00007FFF, 1'b0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b101, 32'h00000001, 32'h0,        0, 0, -1, 32'h0,        1'b0, 1'b0, 0, 32'h00007FFF, 1'b0, 1'b0, 4'h0, 32'h0);

        $display("[TB] bus error and kill");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        1, 1, -1, 32'h0,        1'b0, 1'b0, 2, 32'h00007FFF, 1'b1, 1'b1, 4'hF, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000020, 32'h0,        2, 0, 1,  32'h55555555, 1'b0, 1'b0, 3, 32'h00007FFF, 1'b0, 1'b1, 4'hF, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000030, 32'h0,        0, 0, 0,  32'h55555555, 1'b0, 1'b0, 0, 32'h00007FFF, 1'b0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000050, 32'h0,        0, 1, 1,  32'h0,        1'b0, 1'b0, 1, 32'h00007FFF, 1'b0, 1'b1, 4'hF, 32'h0);

        $display("[TB] watchdog on short-timeout instance");
        validTo = 1'b1; isLd = 1'b1; funct3 = 3'b010; addrIn = 32'h0;
        cycCnt = 0; stallCnt = 0; done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (cycTo) cycCnt++;
            if (stallTo) stallCnt++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        validTo = 1'b0; isLd = 1'b0;
        checkOutput("to_cycHighCycles", cycCnt, 32'd4);
        checkOutput("to_stallCycles", stallCnt, 32'd4);
        @(negedge clk);
        checkOutput("to_cycDropped", {31'b0, cycTo}, 32'd0);
        checkOutput("to_busErrPulse", {31'b0, busErrTo}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("to_busErrEnd", {31'b0, busErrTo}, 32'd0);
        @(posedge clk); #1;

        $display("[TB] reset during bus cycle");
        reqQ.push_back('{adr: 32'h40, sel: 4'hF, dat: 32'h0, we: 1'b0, memAddr: 32'h40});
        respQ.push_back('{ld: 32'h0, err: 1'b0, memAddr: 32'h0});
        valid = 1'b1; isLd = 1'b1; funct3 = 3'b010; addrIn = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid = 1'b0; isLd = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstMid_cyc", {31'b0, cyc}, 32'd0);
        checkOutput("rstMid_stb", {31'b0, stb}, 32'd0);
        checkOutput("rstMid_adr", adr, 32'd0);
        checkOutput("rstMid_sel", {28'b0, sel}, 32'd0);
        checkOutput("rstMid_ld_data", ldData, 32'd0);
        checkOutput("rstMid_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rstRel_bus_err", {31'b0, busErr}, 32'd0);
        @(negedge clk);
        checkOutput("rstRel_bus_err2", {31'b0, busErr}, 32'd0);
        checkOutput("rstRel_cyc", {31'b0, cyc}, 32'd0);

        for (int i = 0; i < 20 && (reqQ.size() != 0 || respQ.size() != 0); i++) @(negedge clk);
        checkOutput("reqQueueLeft", reqQ.size(), 32'd0);
        checkOutput("respQueueLeft", respQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
